// File: rtl/fib_seq_ctrl.sv
// Fibonacci term generator: emits one 8-bit term every DECIMATION clocks for
// a requested number of terms, with a sticky modulo-256 wrap flag and abort.
module fib_seq_ctrl #(
  parameter logic [19:0] DECIMATION = 20'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] count,
  input  logic       abort,
  output logic       busy,
  output logic [7:0] term,
  output logic       term_valid,
  output logic [7:0] term_idx,
  output logic       overflow,
  output logic       done
);

  // A DECIMATION of 0 behaves like 1: tick on every RUN cycle.
  localparam logic [19:0] DEC_MAX = (DECIMATION == 20'd0) ? 20'd0 : DECIMATION - 20'd1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_bCarry;
  logic [7:0]  r_count;
  logic [7:0]  r_emitted;
  logic [19:0] r_decCnt;

  logic [8:0]  w_sum;
  logic        w_tick;
  logic        w_finish;

  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_tick   = (r_decCnt == DEC_MAX);
  assign w_finish = abort || (r_emitted == r_count);

  // r_bCarry remembers that the pending term in b came from a wrapped sum, so
  // overflow rises together with the pulse that presents that term.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= 8'd0;
      r_b        <= 8'd1;
      r_bCarry   <= 1'b0;
      r_count    <= 8'd0;
      r_emitted  <= 8'd0;
      r_decCnt   <= 20'd0;
      busy       <= 1'b0;
      term       <= 8'd0;
      term_valid <= 1'b0;
      term_idx   <= 8'd0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      term_valid <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= 8'd0;
            r_b       <= 8'd1;
            r_bCarry  <= 1'b0;
            r_count   <= count;
            r_emitted <= 8'd0;
            r_decCnt  <= 20'd0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            if (count == 8'd0) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          // Finishing is decided one cycle after the last pulse so that done
          // never shares a cycle with term_valid; abort beats a same-cycle tick.
          if (w_finish) begin
            r_state <= DONE;
            done    <= 1'b1;
          end else begin
            r_decCnt <= w_tick ? 20'd0 : r_decCnt + 20'd1;
            if (w_tick) begin
              term             <= r_b;
              term_valid       <= 1'b1;
              term_idx         <= r_emitted;
              overflow         <= overflow | r_bCarry;
              r_emitted        <= r_emitted + 8'd1;
              r_a              <= r_b;
              {r_bCarry, r_b}  <= w_sum;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, on ports clk and reset.
REQ-002 The block SHALL have parameter DECIMATION, default 20'd16, giving clock cycles between emitted terms; 0 is treated as 1.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port start  input  1  run request, sampled only in IDLE.
REQ-006 Port count  input  8  number of terms to emit, sampled on the accepted start edge.
REQ-007 Port abort  input  1  terminate the current run, sampled only in RUN.
REQ-008 Port busy  output  1  high in RUN and DONE.
REQ-009 Port term  output  8  last emitted Fibonacci term, held between pulses.
REQ-010 Port term_valid  output  1  one-cycle pulse per emitted term.
REQ-011 Port term_idx  output  8  0-based index of the last emitted term, held.
REQ-012 Port overflow  output  1  sticky flag: an emitted term wrapped modulo 256.
REQ-013 Port done  output  1  one-cycle pulse marking run end.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE.
REQ-016 The datapath SHALL use internal 8-bit registers a and b; on an accepted start it loads a=0 and b=1, and clears the decimation counter, the emitted-term counter and overflow.
REQ-017 On start=1 in IDLE with count!=0, the next state SHALL be RUN; with count==0, the next state SHALL be DONE and no term is emitted.
REQ-018 A 20-bit decimation counter in RUN SHALL count 0..DECIMATION-1 and wrap; a tick occurs when it equals DECIMATION-1.
REQ-019 On a tick, the block SHALL register term<=b, term_valid<=1 and term_idx<=emitted count, then advance a<=b and b<=(a+b) mod 256, keeping the carry bit.
REQ-020 Timing: the first term_valid SHALL be high in cycle DECIMATION+1 after the accept edge, and later pulses SHALL be DECIMATION cycles apart.
REQ-021 Term sequence SHALL be 1,1,2,3,5,8,13,21,34,55,89,144,233,121(wrapped),...
REQ-022 overflow SHALL rise in the same cycle as term_valid for the first emitted term whose value was produced by a carried sum.
REQ-023 overflow SHALL stay high through DONE and IDLE until the next accepted start or reset.
REQ-024 After the term with index count-1 is emitted, the next state SHALL be DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1 and busy=1, then go to IDLE.
REQ-026 abort=1 in RUN SHALL force the next state to DONE; if a tick coincides with abort, abort wins and no term is emitted.
REQ-027 start while busy SHALL be ignored; abort in IDLE or DONE SHALL be ignored; start and abort together in IDLE SHALL mean the start is accepted.
REQ-028 Between pulses, term and term_idx SHALL hold their values, including in IDLE after a run.

Reset
REQ-029 Asserting reset SHALL immediately, without a clock edge, force state IDLE and busy=0, term=0, term_valid=0, term_idx=0, overflow=0, done=0, with a=0, b=1 and all counters 0.
REQ-030 Reset asserted mid-run SHALL abandon the run with no done pulse; a new start is required after release.

Verification
REQ-031 DECIMATION=1, start with count=5 -> term_valid on 5 consecutive cycles starting cycle 2 after accept; terms 1,1,2,3,5; idx 0..4; done the cycle after the last pulse; overflow=0.
REQ-032 DECIMATION=4, count=3 -> term_valid in cycles 5, 9 and 13 after accept, with values 1,1,2; done in cycle 14.
REQ-033 DECIMATION=1, count=14 -> idx 12 term=233 with overflow=0; idx 13 term=121 with overflow=1; overflow still 1 in IDLE and cleared by the next start.
REQ-034 count=0 -> no term_valid; busy=1 and done=1 for exactly one cycle after accept; term and term_idx keep their prior values.
REQ-035 DECIMATION=1, count=10, abort raised in the cycle after idx 3 -> no further terms, done next cycle, term_idx=3; a start during RUN or DONE is ignored.
REQ-036 Reset pulsed asynchronously mid-run between clock edges -> all outputs 0 before the next edge; after release, start with count=2 yields terms 1,1.
